// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Sits between the UART receiver and the system register file. It decodes
//   received bytes into write frames (CMD_WR, addr, data) and read frames
//   (CMD_RD, addr). It issues register-file write and read strobes and
//   returns read data to the UART transmitter. Frames are aborted on line
//   errors or on inter-byte timeout, and line errors are counted.
//
// Ports
//   CLK, RST        clock (posedge) and asynchronous active-low reset
//   RX_P_DATA       received byte
//   RX_D_VLD        one-cycle pulse per received byte
//   RX_PAR_ERR      parity error, qualified by RX_D_VLD
//   RX_STP_ERR      stop-bit error, qualified by RX_D_VLD
//   RF_WR_EN        one-cycle register-file write strobe
//   RF_RD_EN        one-cycle register-file read strobe
//   RF_ADDR         register-file address, held until the next address byte
//   RF_WR_DATA      register-file write data, held until the next data byte
//   RF_RD_DATA      register-file read data, qualified by RF_RD_VLD
//   RF_RD_VLD       read-data valid pulse
//   TX_P_DATA       byte handed to UART_TX
//   TX_D_VLD        one-cycle byte-valid pulse to UART_TX
//   TX_BUSY         UART_TX busy
//   ERR_CLR         synchronous clear of ERR_CNT
//   BUSY            high whenever the FSM is not idle
//   FRAME_ERR       one-cycle pulse on a frame abort or a dropped byte
//   ERR_CNT         saturating line-error counter
//   DBG_STATE       current FSM state encoding, for observation only
//
// Transmit handshake: TX_D_VLD is a single-cycle pulse issued only after a
// clock edge that sampled TX_BUSY low; while TX_BUSY stays high the byte is
// held in TX_P_DATA and the FSM waits without limit.
module uart_rx_frame_ctrl #(
   parameter int               width   = 8,
   parameter int               ADDR_W  = 4,
   parameter int               TIMEOUT = 1024,
   parameter logic [width-1:0] CMD_WR  = 8'hAA,
   parameter logic [width-1:0] CMD_RD  = 8'hBB
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [width-1:0]  RX_P_DATA,
   input  logic              RX_D_VLD,
   input  logic              RX_PAR_ERR,
   input  logic              RX_STP_ERR,
   output logic              RF_WR_EN,
   output logic              RF_RD_EN,
   output logic [ADDR_W-1:0] RF_ADDR,
   output logic [width-1:0]  RF_WR_DATA,
   input  logic [width-1:0]  RF_RD_DATA,
   input  logic              RF_RD_VLD,
   output logic [width-1:0]  TX_P_DATA,
   output logic              TX_D_VLD,
   input  logic              TX_BUSY,
   input  logic              ERR_CLR,
   output logic              BUSY,
   output logic              FRAME_ERR,
   output logic [7:0]        ERR_CNT,
   output logic [2:0]        DBG_STATE
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_EXEC = 3'd3,
      RD_ADDR = 3'd4,
      RD_EXEC = 3'd5,
      RD_WAIT = 3'd6,
      TX_SEND = 3'd7
   } state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     tcnt, tcnt_nxt;
   logic              valid_byte, err_byte, timed, expire;
   logic [ADDR_W-1:0] addr_nxt;
   logic [width-1:0]  wdata_nxt, txd_nxt;
   logic              frame_err_nxt, tx_vld_nxt;
   logic [7:0]        err_cnt_nxt;

   assign valid_byte = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
   assign err_byte   = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);
   assign timed      = (state == WR_ADDR) || (state == WR_DATA) ||
                       (state == RD_ADDR) || (state == RD_WAIT);
   // A valid byte landing on the expiry cycle restarts the count, so it wins.
   assign expire     = timed && (tcnt == TW'(TIMEOUT - 1)) && !valid_byte;
   assign DBG_STATE  = state;

   always_comb begin
      state_nxt     = state;
      addr_nxt      = RF_ADDR;
      wdata_nxt     = RF_WR_DATA;
      txd_nxt       = TX_P_DATA;
      frame_err_nxt = 1'b0;
      tx_vld_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (valid_byte) begin
               if (RX_P_DATA == CMD_WR)      state_nxt = WR_ADDR;
               else if (RX_P_DATA == CMD_RD) state_nxt = RD_ADDR;
               else                          frame_err_nxt = 1'b1;
            end
         end
         WR_ADDR, RD_ADDR: begin
            if (valid_byte) begin
               addr_nxt  = RX_P_DATA[ADDR_W-1:0];
               state_nxt = (state == WR_ADDR) ? WR_DATA : RD_EXEC;
            end else if (err_byte || expire) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end
         end
         WR_DATA: begin
            if (valid_byte) begin
               wdata_nxt = RX_P_DATA;
               state_nxt = WR_EXEC;
            end else if (err_byte || expire) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end
         end
         WR_EXEC: begin
            state_nxt     = IDLE;
            frame_err_nxt = RX_D_VLD;
         end
         RD_EXEC: begin
            state_nxt     = RD_WAIT;
            frame_err_nxt = RX_D_VLD;
         end
         RD_WAIT: begin
            frame_err_nxt = RX_D_VLD;
            if (RF_RD_VLD) begin
               txd_nxt   = RF_RD_DATA;
               state_nxt = TX_SEND;
            end else if (expire) begin
               state_nxt     = IDLE;
               frame_err_nxt = 1'b1;
            end
         end
         TX_SEND: begin
            frame_err_nxt = RX_D_VLD;
            if (!TX_BUSY) begin
               tx_vld_nxt = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tcnt_nxt = '0;
      if (state_nxt == state && timed && !valid_byte)
         tcnt_nxt = tcnt + TW'(1);
   end

   always_comb begin
      err_cnt_nxt = ERR_CNT;
      if (ERR_CLR)
         err_cnt_nxt = 8'h00;
      else if (err_byte && ERR_CNT != 8'hFF)
         err_cnt_nxt = ERR_CNT + 8'h01;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= IDLE;
         tcnt       <= '0;
         RF_WR_EN   <= 1'b0;
         RF_RD_EN   <= 1'b0;
         RF_ADDR    <= '0;
         RF_WR_DATA <= '0;
         TX_P_DATA  <= '0;
         TX_D_VLD   <= 1'b0;
         BUSY       <= 1'b0;
         FRAME_ERR  <= 1'b0;
         ERR_CNT    <= 8'h00;
      end else begin
         state      <= state_nxt;
         tcnt       <= tcnt_nxt;
         // Strobes are high exactly while the FSM sits in its execute state.
         RF_WR_EN   <= (state_nxt == WR_EXEC);
         RF_RD_EN   <= (state_nxt == RD_EXEC);
         RF_ADDR    <= addr_nxt;
         RF_WR_DATA <= wdata_nxt;
         TX_P_DATA  <= txd_nxt;
         TX_D_VLD   <= tx_vld_nxt;
         BUSY       <= (state_nxt != IDLE);
         FRAME_ERR  <= frame_err_nxt;
         ERR_CNT    <= err_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam int T = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd6;
  localparam logic [2:0] S_TX_SEND = 3'd7;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       RX_PAR_ERR = 1'b0;
  logic       RX_STP_ERR = 1'b0;
  logic       RF_WR_EN, RF_RD_EN;
  logic [3:0] RF_ADDR;
  logic [7:0] RF_WR_DATA;
  logic [7:0] RF_RD_DATA = '0;
  logic       RF_RD_VLD = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic       BUSY, FRAME_ERR;
  logic [7:0] ERR_CNT;
  logic [2:0] DBG_STATE;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0;
  int wr_base, rd_base, tx_base;

  uart_rx_frame_ctrl #(.width(8), .ADDR_W(4), .TIMEOUT(T),
                       .CMD_WR(8'hAA), .CMD_RD(8'hBB)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_ADDR(RF_ADDR),
    .RF_WR_DATA(RF_WR_DATA), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .ERR_CLR(ERR_CLR), .BUSY(BUSY), .FRAME_ERR(FRAME_ERR),
    .ERR_CNT(ERR_CNT), .DBG_STATE(DBG_STATE)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_summary expected=summary_before_200us");
    $fatal(1, "watchdog expired");
  end

  // pulse counters and strobe exclusivity, sampled at the active edge
  always @(posedge CLK) begin
    if (RST) begin
      checks++;
      assert ($onehot0({RF_WR_EN, RF_RD_EN, TX_D_VLD})) else begin
        failures++;
        $error("FAIL strobe_onehot observed=%b expected=at_most_one_high",
               {RF_WR_EN, RF_RD_EN, TX_D_VLD});
      end
      if (RF_WR_EN) wr_cnt++;
      if (RF_RD_EN) rd_cnt++;
      if (TX_D_VLD) tx_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
    RX_P_DATA  = b;
    RX_D_VLD   = 1'b1;
    RX_PAR_ERR = pe;
    RX_STP_ERR = se;
    @(negedge CLK);
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_STP_ERR = 1'b0;
  endtask

  task automatic snap();
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    tx_base = tx_cnt;
  endtask

  initial begin
    // reset
    #1 RST = 1'b0;
    step(2);
    check("reset_outputs",
          {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, TX_P_DATA, TX_D_VLD, BUSY, FRAME_ERR, ERR_CNT, DBG_STATE},
          32'h0);
    RST = 1'b1;
    step(1);

    // 1: write AA 03 5C with gaps
    snap();
    send_byte(8'hAA, 0, 0);
    check("wr_busy_after_cmd", BUSY, 1);
    check("wr_state_after_cmd", DBG_STATE, S_WR_ADDR);
    step(3);
    send_byte(8'h03, 0, 0);
    check("wr_addr_latched", RF_ADDR, 4'h3);
    step(2);
    send_byte(8'h5C, 0, 0);
    check("wr_en_latency", RF_WR_EN, 1);
    check("wr_data", RF_WR_DATA, 8'h5C);
    check("wr_addr", RF_ADDR, 4'h3);
    step(1);
    check("wr_en_one_cycle", RF_WR_EN, 0);
    check("wr_busy_low", BUSY, 0);
    check("wr_err_cnt", ERR_CNT, 8'h00);
    check("wr_addr_held", RF_ADDR, 4'h3);
    step(1);
    check("wr_pulse_count", wr_cnt - wr_base, 1);

    // 2: read BB 07, data C3 two cycles after RF_RD_EN, TX_BUSY 5 cycles
    snap();
    send_byte(8'hBB, 0, 0);
    step(1);
    send_byte(8'h07, 0, 0);
    check("rd_en_latency", RF_RD_EN, 1);
    check("rd_addr", RF_ADDR, 4'h7);
    step(1);
    check("rd_en_one_cycle", RF_RD_EN, 0);
    check("rd_wait_state", DBG_STATE, S_RD_WAIT);
    step(1);
    RF_RD_DATA = 8'hC3;
    RF_RD_VLD  = 1'b1;
    TX_BUSY    = 1'b1;
    step(1);
    RF_RD_VLD  = 1'b0;
    RF_RD_DATA = 8'h00;
    check("rd_tx_data_latched", TX_P_DATA, 8'hC3);
    check("rd_tx_send_state", DBG_STATE, S_TX_SEND);
    step(4);
    check("rd_tx_held_while_busy", TX_D_VLD, 0);
    check("rd_busy_while_tx_busy", BUSY, 1);
    TX_BUSY = 1'b0;
    step(1);
    check("rd_tx_vld", TX_D_VLD, 1);
    check("rd_tx_data", TX_P_DATA, 8'hC3);
    check("rd_busy_low", BUSY, 0);
    step(1);
    check("rd_tx_vld_one_cycle", TX_D_VLD, 0);
    check("rd_tx_pulse_count", tx_cnt - tx_base, 1);
    check("rd_rd_pulse_count", rd_cnt - rd_base, 1);
    check("rd_no_write", wr_cnt - wr_base, 0);

    // 3: parity error aborts, then a normal write
    snap();
    send_byte(8'hAA, 0, 0);
    send_byte(8'h02, 1, 0);
    check("par_frame_err", FRAME_ERR, 1);
    check("par_err_cnt", ERR_CNT, 8'h01);
    check("par_idle", DBG_STATE, S_IDLE);
    step(1);
    check("par_frame_err_one_cycle", FRAME_ERR, 0);
    check("par_no_write", wr_cnt - wr_base, 0);
    send_byte(8'hAA, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h11, 0, 0);
    check("par_retry_wr_en", RF_WR_EN, 1);
    check("par_retry_addr", RF_ADDR, 4'h2);
    check("par_retry_data", RF_WR_DATA, 8'h11);
    step(1);

    // 4: timeout after the address byte
    snap();
    send_byte(8'hAA, 0, 0);
    send_byte(8'h04, 0, 0);
    step(T - 1);
    check("to_not_yet", FRAME_ERR, 0);
    check("to_still_busy", BUSY, 1);
    step(1);
    check("to_frame_err", FRAME_ERR, 1);
    check("to_idle", BUSY, 0);
    step(1);
    check("to_no_write", wr_cnt - wr_base, 0);
    // byte arriving exactly on the expiry cycle wins
    send_byte(8'hAA, 0, 0);
    step(T - 1);
    send_byte(8'h06, 0, 0);
    check("to_edge_byte_wins_state", DBG_STATE, S_WR_DATA);
    check("to_edge_no_frame_err", FRAME_ERR, 0);
    send_byte(8'h77, 0, 0);
    check("to_edge_write", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h6, 8'h77});
    step(1);
    // next read frame completes
    snap();
    send_byte(8'hBB, 0, 0);
    send_byte(8'h09, 0, 0);
    step(1);
    RF_RD_DATA = 8'h5A;
    RF_RD_VLD  = 1'b1;
    step(1);
    RF_RD_VLD  = 1'b0;
    step(1);
    check("to_read_tx", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h5A});
    step(1);
    check("to_read_tx_count", tx_cnt - tx_base, 1);

    // 5: unknown opcode, error counter saturation, clear priority
    ERR_CLR = 1'b1;
    step(1);
    ERR_CLR = 1'b0;
    check("clr_err_cnt", ERR_CNT, 8'h00);
    send_byte(8'h3C, 0, 0);
    check("unk_frame_err", FRAME_ERR, 1);
    check("unk_idle", {BUSY, DBG_STATE}, {1'b0, S_IDLE});
    send_byte(8'h55, 0, 1);
    check("idle_err_no_frame_err", FRAME_ERR, 0);
    check("idle_err_counted", ERR_CNT, 8'h01);
    for (int i = 0; i < 253; i++) send_byte(8'(i), i[0], ~i[0]);
    check("err_cnt_fe", ERR_CNT, 8'hFE);
    send_byte(8'h00, 1, 0);
    send_byte(8'h00, 1, 1);
    check("err_cnt_saturate", ERR_CNT, 8'hFF);
    send_byte(8'h00, 0, 1);
    check("err_cnt_hold_ff", ERR_CNT, 8'hFF);
    ERR_CLR = 1'b1;
    send_byte(8'h00, 1, 0);
    ERR_CLR = 1'b0;
    check("clr_beats_incr", ERR_CNT, 8'h00);

    // 6: reset while waiting for read data
    snap();
    send_byte(8'hBB, 0, 0);
    send_byte(8'h05, 0, 0);
    step(1);
    check("rst_pre_state", DBG_STATE, S_RD_WAIT);
    send_byte(8'h12, 0, 1);
    check("drop_frame_err", FRAME_ERR, 1);
    check("drop_counted", ERR_CNT, 8'h01);
    check("drop_state_kept", DBG_STATE, S_RD_WAIT);
    #2 RST = 1'b0;
    #1;
    check("rst_async_outputs",
          {RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, TX_P_DATA, TX_D_VLD, BUSY, FRAME_ERR, ERR_CNT, DBG_STATE},
          32'h0);
    @(negedge CLK);
    RST = 1'b1;
    snap();
    RF_RD_DATA = 8'hEE;
    RF_RD_VLD  = 1'b1;
    step(1);
    RF_RD_VLD  = 1'b0;
    step(1);
    check("rst_rd_vld_ignored", {BUSY, TX_P_DATA, DBG_STATE}, {1'b0, 8'h00, S_IDLE});
    check("rst_no_tx", tx_cnt - tx_base, 0);
    send_byte(8'hAA, 0, 0);
    send_byte(8'h1F, 0, 0);
    check("addr_truncation", RF_ADDR, 4'hF);
    send_byte(8'h99, 0, 0);
    check("rst_new_write", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'hF, 8'h99});
    step(2);
    check("rst_new_write_count", wr_cnt - wr_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
